// File: rtl/sys_ctrl_host.sv
// Host-side command sequencer: frames a command into UART bytes, waits for a
// one-byte reply (or timeout) and reports it as a single-cycle response.
module sys_ctrl_host #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_err,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned TO_W   = 17;
  localparam int unsigned CNT_W  = 2;

  localparam logic [BYTE_W-1:0] OP_WRITE = 8'h02;
  localparam logic [BYTE_W-1:0] OP_READ  = 8'h03;
  localparam logic [BYTE_W-1:0] OP_MAX   = 8'h07;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    WAIT_RSP,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    last_idx_q, last_idx_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [BYTE_W-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;

  // Byte idx of the frame: op, addr hi, addr lo, data.
  function automatic logic [BYTE_W-1:0] sel_byte(
    input logic [CNT_W-1:0]  idx,
    input logic [BYTE_W-1:0] op,
    input logic [ADDR_W-1:0] addr,
    input logic [BYTE_W-1:0] data
  );
    case (idx)
      2'd0:    sel_byte = op;
      2'd1:    sel_byte = addr[15:8];
      2'd2:    sel_byte = addr[7:0];
      default: sel_byte = data;
    endcase
  endfunction

  // RESP is the response-pulse cycle; it accepts commands exactly like IDLE.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    last_idx_d  = last_idx_q;
    to_cnt_d    = to_cnt_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (cmd_valid) begin
          op_d     = cmd_op;
          addr_d   = cmd_addr;
          data_d   = cmd_data;
          cnt_d    = '0;
          to_cnt_d = '0;
          if (cmd_op > OP_MAX) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ILLEGAL;
            rsp_data_d  = '0;
          end else begin
            state_d    = SEND;
            tx_start_d = 1'b1;
            tx_data_d  = cmd_op;
            if (cmd_op == OP_WRITE) begin
              last_idx_d = 2'd3;
            end else if (cmd_op == OP_READ) begin
              last_idx_d = 2'd2;
            end else begin
              last_idx_d = 2'd0;
            end
          end
        end
      end
      SEND: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (cnt_q == last_idx_q) begin
            state_d  = WAIT_RSP;
            to_cnt_d = '0;
          end else begin
            state_d    = SEND;
            cnt_d      = cnt_q + 2'd1;
            tx_start_d = 1'b1;
            tx_data_d  = sel_byte(cnt_q + 2'd1, op_q, addr_q, data_q);
          end
        end
      end
      WAIT_RSP: begin
        if (rx_valid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_data;
          rsp_err_d   = ((op_q == OP_READ) || (rx_data == 8'h00)) ? ERR_OK : ERR_NACK;
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = ERR_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + 17'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE) || (state_d == RESP);
    busy_d      = ~cmd_ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      last_idx_q  <= '0;
      to_cnt_q    <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      last_idx_q  <= last_idx_d;
      to_cnt_q    <= to_cnt_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sys_ctrl_host.sv
// Bench for sys_ctrl_host: table vectors, randomized commands against a
// frame/response model, and a reset-mid-command sequence.
module tb_sys_ctrl_host;

  localparam int unsigned T = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_err;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
    int          tx_dly;
    bit          rx_en;
    logic [7:0]  rx_b;
    int          rx_dly;
    bit          noise;
    int          exp_n;
    logic [1:0]  exp_err;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[$];

  sys_ctrl_host #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Frame length and byte order straight from the opcode rules.
  function automatic int model_len(input logic [7:0] op);
    if (op > 8'h07) return 0;
    if (op == 8'h02) return 4;
    if (op == 8'h03) return 3;
    return 1;
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [15:0] addr,
                                            input logic [7:0] data, input int i);
    case (i)
      0:       return op;
      1:       return addr[15:8];
      2:       return addr[7:0];
      default: return data;
    endcase
  endfunction

  task automatic model_rsp(input logic [7:0] op, input bit rx_en, input logic [7:0] rx_b,
                           input int rx_dly, output logic [1:0] err, output logic [7:0] data);
    if (op > 8'h07) begin
      err = 2'b11; data = 8'h00;
    end else if (!rx_en || rx_dly > int'(T)) begin
      err = 2'b01; data = 8'h00;
    end else if (op == 8'h03) begin
      err = 2'b00; data = rx_b;
    end else begin
      err = (rx_b == 8'h00) ? 2'b00 : 2'b10; data = rx_b;
    end
  endtask

  // Issue one command, play the UART side, and check frame, timing and response.
  task automatic run_cmd(input vec_t v, input string nm);
    int acc, last_done, next_done, rx_at, rsp_cyc, exp_cyc, busy_bad, nb;
    bit got_rsp, g_ready;
    logic [7:0] got_b [4];
    logic [7:0] g_data;
    logic [1:0] g_err;
    nb = 0; busy_bad = 0; got_rsp = 0; g_ready = 0;
    last_done = -1; next_done = -1; rx_at = -1; rsp_cyc = -1;
    g_data = 8'h00; g_err = 2'b00;
    for (int i = 0; i < 4; i++) got_b[i] = 8'h00;
    for (int i = 0; i < 20 && !cmd_ready; i++) step();
    chk({nm, "/ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_data = v.data;
    acc = cyc;
    step();
    cmd_valid = 1'b0;
    cmd_op = 8'($urandom); cmd_addr = 16'($urandom); cmd_data = 8'($urandom);
    for (int i = 0; i < 3000 && !got_rsp; i++) begin
      tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'($urandom);
      if (rsp_valid) begin
        got_rsp = 1; rsp_cyc = cyc; g_data = rsp_data; g_err = rsp_err; g_ready = cmd_ready;
      end else if (cmd_ready || !busy) begin
        busy_bad++;
      end
      if (tx_start) begin
        exp_cyc = (nb == 0) ? acc + 1 : last_done + 1;
        chk($sformatf("%s/start%0d_cycle", nm, nb), cyc, exp_cyc);
        if (nb < 4) got_b[nb] = tx_data;
        nb++;
        next_done = cyc + v.tx_dly;
        if (v.noise) tx_done = 1'b1;
      end else if (v.noise && next_done == cyc + 1) begin
        rx_valid = 1'b1; rx_data = 8'h5A;
      end
      if (cyc == next_done) begin
        tx_done = 1'b1; last_done = cyc; next_done = -1;
        if (nb == v.exp_n && v.rx_en) rx_at = cyc + v.rx_dly;
      end
      if (cyc == rx_at) begin
        rx_valid = 1'b1; rx_data = v.rx_b;
      end
      if (!got_rsp) step();
    end
    chk({nm, "/rsp_seen"}, 32'(got_rsp), 32'd1);
    chk({nm, "/nbytes"}, nb, v.exp_n);
    for (int i = 0; i < v.exp_n && i < nb && i < 4; i++)
      chk($sformatf("%s/byte%0d", nm, i), 32'(got_b[i]), 32'(model_byte(v.op, v.addr, v.data, i)));
    if (v.op > 8'h07) exp_cyc = acc + 1;
    else if (v.rx_en && v.rx_dly <= int'(T)) exp_cyc = rx_at + 1;
    else exp_cyc = last_done + int'(T) + 1;
    chk({nm, "/rsp_cycle"}, rsp_cyc, exp_cyc);
    chk({nm, "/rsp_err"}, 32'(g_err), 32'(v.exp_err));
    chk({nm, "/rsp_data"}, 32'(g_data), 32'(v.exp_data));
    chk({nm, "/ready_at_rsp"}, 32'(g_ready), 32'd1);
    chk({nm, "/busy_cycles_bad"}, busy_bad, 0);
    step();
    chk({nm, "/rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    chk({nm, "/rsp_data_hold"}, 32'(rsp_data), 32'(v.exp_data));
    chk({nm, "/rsp_err_hold"}, 32'(rsp_err), 32'(v.exp_err));
    tx_done = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "/cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({nm, "/busy"}, 32'(busy), 32'd0);
    chk({nm, "/tx_start"}, 32'(tx_start), 32'd0);
    chk({nm, "/tx_data"}, 32'(tx_data), 32'd0);
    chk({nm, "/rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "/rsp_data"}, 32'(rsp_data), 32'd0);
    chk({nm, "/rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  // Abandon a WRITE after its second byte; stray bytes afterwards must be ignored.
  task automatic reset_mid();
    int dones, pend, bad_tx, bad_rsp, bad_rdy;
    dones = 0; pend = -1; bad_tx = 0; bad_rsp = 0; bad_rdy = 0;
    for (int i = 0; i < 20 && !cmd_ready; i++) step();
    cmd_valid = 1'b1; cmd_op = 8'h02; cmd_addr = 16'h4321; cmd_data = 8'h99;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 && dones < 2; i++) begin
      tx_done = 1'b0;
      if (tx_start) pend = cyc + 3;
      if (cyc == pend) begin tx_done = 1'b1; dones++; pend = -1; end
      step();
    end
    tx_done = 1'b0;
    chk("rstmid/dones", dones, 2);
    chk("rstmid/third_start", 32'(tx_start), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("rstmid");
    for (int i = 0; i < 40; i++) begin
      tx_done = (i == 5); rx_valid = (i == 2); rx_data = 8'h00;
      step();
      if (tx_start) bad_tx++;
      if (rsp_valid) bad_rsp++;
      if (!cmd_ready) bad_rdy++;
    end
    tx_done = 1'b0; rx_valid = 1'b0;
    chk("rstmid/tx_start_after", bad_tx, 0);
    chk("rstmid/rsp_after", bad_rsp, 0);
    chk("rstmid/ready_low_after", bad_rdy, 0);
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 8'h00; cmd_addr = 16'h0000; cmd_data = 8'h00;
    tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    //            op     addr      data   txd rx  rx_b   rxd           nz   n  err    data
    vecs.push_back('{8'h05, 16'h0000, 8'h00, 2,  1'b1, 8'h00, 3,            1'b0, 1, 2'b00, 8'h00});
    vecs.push_back('{8'h02, 16'h1234, 8'hAB, 20, 1'b1, 8'h00, 4,            1'b0, 4, 2'b00, 8'h00});
    vecs.push_back('{8'h03, 16'h8000, 8'h00, 3,  1'b1, 8'h5A, 2,            1'b0, 3, 2'b00, 8'h5A});
    vecs.push_back('{8'h03, 16'h8000, 8'h00, 3,  1'b1, 8'hFF, 1,            1'b1, 3, 2'b00, 8'hFF});
    vecs.push_back('{8'h00, 16'h0000, 8'h00, 2,  1'b0, 8'h00, 1,            1'b0, 1, 2'b01, 8'h00});
    vecs.push_back('{8'h00, 16'h0000, 8'h00, 2,  1'b1, 8'h07, 5,            1'b0, 1, 2'b10, 8'h07});
    vecs.push_back('{8'h09, 16'h5555, 8'h66, 2,  1'b1, 8'h00, 1,            1'b0, 0, 2'b11, 8'h00});
    vecs.push_back('{8'h01, 16'h0000, 8'h00, 1,  1'b1, 8'h00, int'(T),      1'b0, 1, 2'b00, 8'h00});
    vecs.push_back('{8'h04, 16'h0000, 8'h00, 1,  1'b1, 8'h33, int'(T) + 1,  1'b0, 1, 2'b01, 8'h00});
    vecs.push_back('{8'h06, 16'hFFFF, 8'hFF, 1,  1'b1, 8'h80, 1,            1'b1, 1, 2'b10, 8'h80});
    vecs.push_back('{8'h07, 16'h0000, 8'h00, 1,  1'b1, 8'h00, 2,            1'b0, 1, 2'b00, 8'h00});
    vecs.push_back('{8'h02, 16'h00FF, 8'h01, 1,  1'b1, 8'h00, 1,            1'b1, 4, 2'b00, 8'h00});
    vecs.push_back('{8'h06, 16'h0000, 8'h00, 2,  1'b1, 8'h11, 2,            1'b0, 1, 2'b10, 8'h11});
    vecs.push_back('{8'hFF, 16'hABCD, 8'hEF, 1,  1'b1, 8'h00, 1,            1'b0, 0, 2'b11, 8'h00});

    for (int i = 0; i < 3; i++) step();
    check_reset_values("reset");
    rst = 1'b0;
    step();
    chk("reset/ready_after_release", 32'(cmd_ready), 32'd1);

    foreach (vecs[i]) run_cmd(vecs[i], $sformatf("vec%0d", i));

    reset_mid();
    run_cmd(vecs[0], "ping_after_rst");

    for (int i = 0; i < 40; i++) begin
      rv.op     = 8'($urandom_range(0, 11));
      rv.addr   = 16'($urandom);
      rv.data   = 8'($urandom);
      rv.tx_dly = int'($urandom_range(1, 6));
      rv.rx_en  = ($urandom_range(0, 7) != 0);
      rv.rx_b   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      rv.rx_dly = int'($urandom_range(1, 8));
      rv.noise  = ($urandom_range(0, 1) == 1);
      rv.exp_n  = model_len(rv.op);
      model_rsp(rv.op, rv.rx_en, rv.rx_b, rv.rx_dly, rv.exp_err, rv.exp_data);
      run_cmd(rv, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
